// File: rtl/attribute_scanner_pkg.sv
// Shared widths, attribute ids, scanner states and character constants for the
// HTML start-tag attribute scanner.
package attribute_scanner_pkg;

    localparam int CHAR_BITES          = 8;
    localparam int ATTRIBUTE_VAL_BITES = 10;

    localparam logic [2:0] ATTR_NONE   = 3'd0;
    localparam logic [2:0] ATTR_WIDTH  = 3'd1;
    localparam logic [2:0] ATTR_HEIGHT = 3'd2;
    localparam logic [2:0] ATTR_X      = 3'd3;
    localparam logic [2:0] ATTR_Y      = 3'd4;
    localparam logic [2:0] ATTR_SIZE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NAME  = 3'd1,
        ST_EQ    = 3'd2,
        ST_VALUE = 3'd3,
        ST_SKIP  = 3'd4
    } scan_state_t;

    localparam logic [CHAR_BITES-1:0] CH_SPACE = 8'h20;
    localparam logic [CHAR_BITES-1:0] CH_EQ    = 8'h3D;
    localparam logic [CHAR_BITES-1:0] CH_QUOTE = 8'h22;
    localparam logic [CHAR_BITES-1:0] CH_GT    = 8'h3E;

    // ASCII decimal digit to its numeric value; only meaningful for '0'..'9'.
    function automatic logic [3:0] char_to_int(input logic [CHAR_BITES-1:0] ch);
        logic [CHAR_BITES-1:0] diff;
        diff = ch - 8'h30;
        return diff[3:0];
    endfunction

endpackage

// File: rtl/attribute_scanner_if.sv
// Character stream from the tag tokenizer and the attribute result pulses.
interface attribute_scanner_if;
    import attribute_scanner_pkg::*;

    logic [CHAR_BITES-1:0]          char;
    logic                           char_valid;
    logic                           tag_active;
    logic [2:0]                     attr_id;
    logic [ATTRIBUTE_VAL_BITES-1:0] attr_value;
    logic                           attr_valid;
    logic                           attr_error;
    logic                           tag_done;

    modport master (
        output char, char_valid, tag_active,
        input  attr_id, attr_value, attr_valid, attr_error, tag_done
    );

    modport slave (
        input  char, char_valid, tag_active,
        output attr_id, attr_value, attr_valid, attr_error, tag_done
    );
endinterface

// File: rtl/attribute_scanner_name_match.sv
// Classifies a right-aligned, zero-padded name buffer into an attribute id.
module attr_name_match
    import attribute_scanner_pkg::*;
#(
    parameter int NAME_MAX = 6,
    parameter int LEN_BITS = 3
) (
    input  logic [NAME_MAX*CHAR_BITES-1:0] name,
    input  logic [LEN_BITS-1:0]            len,
    output logic [2:0]                     id
);
    localparam int NB = NAME_MAX * CHAR_BITES;

    localparam logic [NB-1:0] NM_WIDTH  = NB'("width");
    localparam logic [NB-1:0] NM_HEIGHT = NB'("height");
    localparam logic [NB-1:0] NM_X      = NB'("x");
    localparam logic [NB-1:0] NM_Y      = NB'("y");
    localparam logic [NB-1:0] NM_SIZE   = NB'("size");

    // Exact lower-case match; an over-long name only keeps its tail, so the length gates it.
    always_comb begin
        id = ATTR_NONE;
        if (int'(len) <= NAME_MAX) begin
            case (name)
                NM_WIDTH:  id = ATTR_WIDTH;
                NM_HEIGHT: id = ATTR_HEIGHT;
                NM_X:      id = ATTR_X;
                NM_Y:      id = ATTR_Y;
                NM_SIZE:   id = ATTR_SIZE;
                default:   id = ATTR_NONE;
            endcase
        end else begin
            id = ATTR_NONE;
        end
    end
endmodule

// File: rtl/attribute_scanner.sv
// Character-serial scanner for name=value attribute pairs inside an HTML start tag;
// emits saturated decimal values for the known numeric attributes.
module attribute_scanner
    import attribute_scanner_pkg::*;
#(
    parameter int NAME_MAX = 6,
    parameter int VAL_MAX  = 1023
) (
    input logic               clock,
    input logic               reset,
    attribute_scanner_if.slave bus
);
    localparam int NB       = NAME_MAX * CHAR_BITES;
    localparam int VB       = ATTRIBUTE_VAL_BITES;
    localparam int LEN_BITS = $clog2(NAME_MAX + 2);
    localparam logic [LEN_BITS-1:0] LEN_SAT   = LEN_BITS'(NAME_MAX + 1);
    localparam logic [13:0]         VAL_MAX_W = 14'(VAL_MAX);
    localparam logic [VB-1:0]       VAL_MAX_V = VB'(VAL_MAX);

    scan_state_t           state_r;
    logic [NB-1:0]         name_buf_r;
    logic [LEN_BITS-1:0]   name_len_r;
    logic [2:0]            id_r;
    logic [VB-1:0]         value_r;
    logic                  quoted_r;
    logic                  have_digit_r;
    logic                  skip_quote_r;
    logic [2:0]            attr_id_r;
    logic [VB-1:0]         attr_value_r;
    logic                  attr_valid_r;
    logic                  attr_error_r;
    logic                  tag_done_r;

    logic [CHAR_BITES-1:0] ch_s;
    logic                  is_digit_s;
    logic                  is_letter_s;
    logic                  is_quote_s;
    logic [3:0]            digit_s;
    logic [13:0]           value_ext_s;
    logic [VB-1:0]         value_sat_s;
    logic [2:0]            match_id_s;

    assign ch_s        = bus.char;
    assign is_digit_s  = (ch_s >= 8'h30) && (ch_s <= 8'h39);
    assign is_letter_s = ((ch_s >= 8'h61) && (ch_s <= 8'h7A)) ||
                         ((ch_s >= 8'h41) && (ch_s <= 8'h5A));
    assign is_quote_s  = (ch_s == CH_QUOTE);
    assign digit_s     = char_to_int(ch_s);
    assign value_ext_s = 14'(value_r) * 14'd10 + 14'(digit_s);
    assign value_sat_s = (value_ext_s > VAL_MAX_W) ? VAL_MAX_V : value_ext_s[VB-1:0];

    attr_name_match #(
        .NAME_MAX (NAME_MAX),
        .LEN_BITS (LEN_BITS)
    ) u_name_match (
        .name (name_buf_r),
        .len  (name_len_r),
        .id   (match_id_s)
    );

    // Scanner FSM with registered result pulses; pulses default low every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            name_buf_r   <= '0;
            name_len_r   <= '0;
            id_r         <= ATTR_NONE;
            value_r      <= '0;
            quoted_r     <= 1'b0;
            have_digit_r <= 1'b0;
            skip_quote_r <= 1'b0;
            attr_id_r    <= ATTR_NONE;
            attr_value_r <= '0;
            attr_valid_r <= 1'b0;
            attr_error_r <= 1'b0;
            tag_done_r   <= 1'b0;
        end else begin
            attr_valid_r <= 1'b0;
            attr_error_r <= 1'b0;
            tag_done_r   <= 1'b0;
            if (!bus.tag_active) begin
                state_r      <= ST_IDLE;
                quoted_r     <= 1'b0;
                skip_quote_r <= 1'b0;
            end else if (bus.char_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        if (is_letter_s) begin
                            name_buf_r <= NB'(ch_s);
                            name_len_r <= LEN_BITS'(1);
                            state_r    <= ST_NAME;
                        end else if (ch_s == CH_SPACE) begin
                            state_r <= ST_IDLE;
                        end else if (ch_s == CH_GT) begin
                            tag_done_r <= 1'b1;
                        end else begin
                            skip_quote_r <= is_quote_s;
                            state_r      <= ST_SKIP;
                        end
                    end
                    ST_NAME: begin
                        if (is_letter_s) begin
                            name_buf_r <= {name_buf_r[NB-CHAR_BITES-1:0], ch_s};
                            if (name_len_r != LEN_SAT) begin
                                name_len_r <= name_len_r + LEN_BITS'(1);
                            end
                        end else if (ch_s == CH_EQ) begin
                            id_r    <= match_id_s;
                            state_r <= ST_EQ;
                        end else if (ch_s == CH_SPACE) begin
                            id_r    <= ATTR_NONE;
                            state_r <= ST_IDLE;
                        end else if (ch_s == CH_GT) begin
                            tag_done_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            skip_quote_r <= is_quote_s;
                            state_r      <= ST_SKIP;
                        end
                    end
                    ST_EQ: begin
                        if (is_quote_s) begin
                            quoted_r     <= 1'b1;
                            value_r      <= '0;
                            have_digit_r <= 1'b0;
                            state_r      <= ST_VALUE;
                        end else if (is_digit_s) begin
                            quoted_r     <= 1'b0;
                            value_r      <= VB'(digit_s);
                            have_digit_r <= 1'b1;
                            state_r      <= ST_VALUE;
                        end else begin
                            attr_error_r <= (id_r != ATTR_NONE);
                            skip_quote_r <= 1'b0;
                            state_r      <= ST_SKIP;
                        end
                    end
                    ST_VALUE: begin
                        if (is_digit_s) begin
                            value_r      <= value_sat_s;
                            have_digit_r <= 1'b1;
                        end else if ((quoted_r && is_quote_s) ||
                                     (!quoted_r && ((ch_s == CH_SPACE) || (ch_s == CH_GT)))) begin
                            // An empty quoted value is the only terminator that reports an error.
                            if (id_r != ATTR_NONE) begin
                                if (have_digit_r) begin
                                    attr_valid_r <= 1'b1;
                                    attr_id_r    <= id_r;
                                    attr_value_r <= value_r;
                                end else begin
                                    attr_error_r <= 1'b1;
                                end
                            end
                            tag_done_r <= (ch_s == CH_GT);
                            quoted_r   <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            attr_error_r <= (id_r != ATTR_NONE);
                            skip_quote_r <= quoted_r ^ is_quote_s;
                            quoted_r     <= 1'b0;
                            state_r      <= ST_SKIP;
                        end
                    end
                    ST_SKIP: begin
                        if (ch_s == CH_GT) begin
                            tag_done_r   <= 1'b1;
                            skip_quote_r <= 1'b0;
                            state_r      <= ST_IDLE;
                        end else if (is_quote_s) begin
                            skip_quote_r <= ~skip_quote_r;
                        end else if ((ch_s == CH_SPACE) && !skip_quote_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_SKIP;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.attr_id    = attr_id_r;
    assign bus.attr_value = attr_value_r;
    assign bus.attr_valid = attr_valid_r;
    assign bus.attr_error = attr_error_r;
    assign bus.tag_done   = tag_done_r;

endmodule

// File: tb/tb_attribute_scanner.sv
// Directed bench for attribute_scanner: a string-level reference parser predicts the
// pulses per character, one process compares every cycle, plus literal spot checks.
module tb_attribute_scanner;
    import attribute_scanner_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    attribute_scanner_if bus ();

    attribute_scanner #(.NAME_MAX(6), .VAL_MAX(1023)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit mv[64];
    bit me[64];
    bit md[64];
    int mid[64];
    int mval[64];

    logic       pend_v, pend_e, pend_d, chk_v, chk_e, chk_d;
    logic [2:0] pend_id, chk_id;
    logic [9:0] pend_val, chk_val;
    bit         check_en = 1'b0;
    int         valid_seen = 0, err_seen = 0, done_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_letter(input byte c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
    endfunction

    function automatic bit is_digit(input byte c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic int lookup(input string name);
        if (name == "width")  return 1;
        if (name == "height") return 2;
        if (name == "x")      return 3;
        if (name == "y")      return 4;
        if (name == "size")   return 5;
        return 0;
    endfunction

    // Discard text from k on, honouring quotes; returns index after the stop char.
    function automatic int skip_from(input string s, input int k0, input bit q0);
        int k = k0;
        bit q = q0;
        while (k < s.len()) begin
            if (s[k] == ">") begin
                md[k] = 1'b1;
                return k + 1;
            end
            if (s[k] == "\"") q = !q;
            else if (s[k] == " " && !q) return k + 1;
            k++;
        end
        return s.len();
    endfunction

    task automatic mark_value(input int pos, input int id, input int v);
        if (id != 0) begin
            mv[pos]   = 1'b1;
            mid[pos]  = id;
            mval[pos] = v;
        end
    endtask

    // Reference: parse the whole string as name=value pairs and mark events by char index.
    task automatic model(input string s);
        int n, i, j, k, m, id, v, nd;
        n = s.len();
        for (int p = 0; p < 64; p++) begin
            mv[p] = 1'b0; me[p] = 1'b0; md[p] = 1'b0; mid[p] = 0; mval[p] = 0;
        end
        i = 0;
        while (i < n) begin
            if (s[i] == " ") begin
                i++;
            end else if (s[i] == ">") begin
                md[i] = 1'b1;
                i++;
            end else if (!is_letter(s[i])) begin
                i = skip_from(s, i, 1'b0);
            end else begin
                j = i;
                while (j < n && is_letter(s[j])) j++;
                if (j >= n) i = n;
                else if (s[j] == " ") i = j + 1;
                else if (s[j] == ">") begin md[j] = 1'b1; i = j + 1; end
                else if (s[j] != "=") i = skip_from(s, j, 1'b0);
                else begin
                    id = lookup(s.substr(i, j - 1));
                    k  = j + 1;
                    if (k >= n) i = n;
                    else if (s[k] == "\"") begin
                        m = k + 1; v = 0; nd = 0;
                        while (m < n && is_digit(s[m])) begin
                            v = v * 10 + (s[m] - "0");
                            if (v > 1023) v = 1023;
                            nd++; m++;
                        end
                        if (m >= n) i = n;
                        else if (s[m] == "\"") begin
                            if (nd == 0) me[m] = (id != 0);
                            else mark_value(m, id, v);
                            i = m + 1;
                        end else begin
                            me[m] = (id != 0);
                            i = skip_from(s, m + 1, 1'b1);
                        end
                    end else if (is_digit(s[k])) begin
                        m = k; v = 0;
                        while (m < n && is_digit(s[m])) begin
                            v = v * 10 + (s[m] - "0");
                            if (v > 1023) v = 1023;
                            m++;
                        end
                        if (m >= n) i = n;
                        else if (s[m] == " " || s[m] == ">") begin
                            mark_value(m, id, v);
                            md[m] = (s[m] == ">");
                            i = m + 1;
                        end else begin
                            me[m] = (id != 0);
                            i = skip_from(s, m + 1, s[m] == "\"");
                        end
                    end else begin
                        me[k] = (id != 0);
                        i = skip_from(s, k + 1, 1'b0);
                    end
                end
            end
        end
    endtask

    function automatic int first_valid();
        for (int p = 0; p < 64; p++) if (mv[p]) return p;
        return -1;
    endfunction

    task automatic put(input byte c, input bit cv, input bit ta,
                       input bit ev, input bit ee, input bit ed, input int eid, input int evl);
        @(posedge clock);
        #1;
        bus.char       = c;
        bus.char_valid = cv;
        bus.tag_active = ta;
        pend_v = ev;
        pend_e = ee;
        pend_d = ed;
        if (ev) begin
            pend_id  = 3'(eid);
            pend_val = 10'(evl);
        end
    endtask

    task automatic send(input string s, input bit gaps);
        model(s);
        for (int p = 0; p < s.len(); p++) begin
            if (gaps) put(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            put(s[p], 1'b1, 1'b1, mv[p], me[p], md[p], mid[p], mval[p]);
        end
        put(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        put(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic send_inactive(input string s);
        for (int p = 0; p < s.len(); p++) put(s[p], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        put(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_attr_id"},    int'(bus.attr_id),    0);
        check({tag, "_attr_value"}, int'(bus.attr_value), 0);
        check({tag, "_attr_valid"}, int'(bus.attr_valid), 0);
        check({tag, "_attr_error"}, int'(bus.attr_error), 0);
        check({tag, "_tag_done"},   int'(bus.tag_done),   0);
    endtask

    task automatic mid_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_zero("midreset");
        check_en = 1'b0;
        bus.char_valid = 1'b0;
        pend_v = 1'b0; pend_e = 1'b0; pend_d = 1'b0; pend_id = 3'd0; pend_val = 10'd0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_en = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            chk_v = pend_v; chk_e = pend_e; chk_d = pend_d;
            chk_id = pend_id; chk_val = pend_val;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (check_en && !reset) begin
                check("cyc_attr_valid", int'(bus.attr_valid), int'(chk_v));
                check("cyc_attr_error", int'(bus.attr_error), int'(chk_e));
                check("cyc_tag_done",   int'(bus.tag_done),   int'(chk_d));
                check("cyc_attr_id",    int'(bus.attr_id),    int'(chk_id));
                check("cyc_attr_value", int'(bus.attr_value), int'(chk_val));
                if (bus.attr_valid) valid_seen++;
                if (bus.attr_error) err_seen++;
                if (bus.tag_done)   done_seen++;
            end
        end
    end

    initial begin
        int v0, e0, d0;
        reset = 1'b1;
        bus.char = 8'h00; bus.char_valid = 1'b0; bus.tag_active = 1'b0;
        pend_v = 1'b0; pend_e = 1'b0; pend_d = 1'b0; pend_id = 3'd0; pend_val = 10'd0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;
        check_en = 1'b1;

        v0 = valid_seen;
        model("width=\"640\" ");
        check("t1_model_valid_pos", first_valid(), 10);
        send("width=\"640\" ", 1'b0);
        check("t1_valid_count", valid_seen - v0, 1);
        check("t1_id", int'(bus.attr_id), 1);
        check("t1_value", int'(bus.attr_value), 640);

        v0 = valid_seen; d0 = done_seen;
        send("height=2000>", 1'b0);
        check("t2_valid_count", valid_seen - v0, 1);
        check("t2_done_count", done_seen - d0, 1);
        check("t2_id", int'(bus.attr_id), 2);
        check("t2_value_sat", int'(bus.attr_value), 1023);

        v0 = valid_seen; e0 = err_seen;
        send("size=\"1x\" x=5 ", 1'b0);
        check("t3_error_count", err_seen - e0, 1);
        check("t3_valid_count", valid_seen - v0, 1);
        check("t3_id", int'(bus.attr_id), 3);
        check("t3_value", int'(bus.attr_value), 5);

        v0 = valid_seen;
        send("colour=\"12\" y=\"7\"", 1'b1);
        check("t4_valid_count", valid_seen - v0, 1);
        check("t4_id", int'(bus.attr_id), 4);
        check("t4_value", int'(bus.attr_value), 7);

        v0 = valid_seen;
        send("width=\"12", 1'b0);
        mid_reset();
        send("x=3 ", 1'b0);
        check("t5_valid_count", valid_seen - v0, 1);
        check("t5_id", int'(bus.attr_id), 3);
        check("t5_value", int'(bus.attr_value), 3);

        v0 = valid_seen; d0 = done_seen;
        send("hidden title=\"a>", 1'b0);
        check("t6_done_count", done_seen - d0, 1);
        send_inactive("b\" x=1 ");
        check("t6_valid_after_drop", valid_seen - v0, 0);
        send("y=9 ", 1'b0);
        check("t6_resync_id", int'(bus.attr_id), 4);
        check("t6_resync_value", int'(bus.attr_value), 9);

        v0 = valid_seen; e0 = err_seen;
        send("abcdefg=5 WIDTH=5 width=\"\" x=7\"q r\" y=2 ", 1'b0);
        check("t7_valid_count", valid_seen - v0, 1);
        check("t7_error_count", err_seen - e0, 2);
        check("t7_id", int'(bus.attr_id), 4);
        check("t7_value", int'(bus.attr_value), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/attribute_scanner.md
# attribute_scanner

Character-serial scanner for the attribute region of an HTML start tag. Consumes one character per accepted cycle and recognises `name=value` pairs for a fixed set of numeric attributes. Converts each decimal value to a binary integer and emits it as a one-cycle result pulse tagged with an attribute id. Sits between the tag tokenizer, which supplies characters after the tag name, and the element/layout registers that latch attribute values.

## Interface
Parameters:
- NAME_MAX, 6: longest attribute name matched, in characters; longer names classify as unknown.
- VAL_MAX, 1023: saturation value; equals the maximum of `ATTRIBUTE_VAL_BITES`.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- char  in  `CHAR_BITES`  ASCII character.
- char_valid  in  1  char is consumed this cycle; ignored when low.
- tag_active  in  1  high while the tokenizer is inside a tag's attribute region.
- attr_id  out  3  0 none, 1 width, 2 height, 3 x, 4 y, 5 size.
- attr_value  out  `ATTRIBUTE_VAL_BITES`  parsed value.
- attr_valid  out  1  one-cycle pulse; attr_id/attr_value valid.
- attr_error  out  1  one-cycle pulse; malformed value for a known attribute.
- tag_done  out  1  one-cycle pulse on `>`.

## Operation
The FSM has five states.
- IDLE:
  - On a valid letter: clear the name buffer, store the letter, go to NAME.
  - On space: stay in IDLE.
  - On `>`: pulse tag_done.
  - On any other character: go to SKIP.
- NAME:
  - On a letter: shift it into the name buffer. The length counter saturates at NAME_MAX+1.
  - On `=`: classify the name and go to EQ. Names are lower-case exact matches: "width", "height", "x", "y", "size". Anything else, or a length above NAME_MAX, classifies as id 0.
  - On space: classify the name as id 0 (attribute without value) and go to IDLE.
  - On `>`: go to IDLE and pulse tag_done.
- EQ:
  - On `"`: set the quoted flag and go to VALUE.
  - On a digit: load the digit and go to VALUE.
  - On anything else: if the id is nonzero, pulse attr_error. Then go to SKIP.
- VALUE:
  - Digit rule: value <= min(value*10 + digit, VAL_MAX). Compute with a 14-bit intermediate, then saturate.
  - Terminators: the closing `"` when quoted; space or `>` when unquoted.
  - On a terminator with id nonzero: pulse attr_valid. With id 0, emit nothing.
  - After a terminator: go to IDLE. A `>` terminator also pulses tag_done.
  - On a non-digit that is not a terminator: pulse attr_error if the id is nonzero, then go to SKIP.
  - An empty quoted value `""` is an error for a known id.
- SKIP:
  - Discard characters until a space (outside quotes) or `>`, then go to IDLE.
  - Track quotes so that `"a b"` is skipped whole.
  - `>` pulses tag_done even inside quotes.
- tag_active low: go to IDLE on the next edge. Drop any partial name or value silently, with no pulses.
- Reset mid-operation: go to IDLE immediately. All outputs go to 0 and buffers clear. No pulse is produced for in-flight data.

## Timing
- Reset values: attr_id=0, attr_value=0, attr_valid=0, attr_error=0, tag_done=0.
- Latency: pulses assert the cycle after the edge that accepts the terminating character. They are registered and last exactly one cycle.
- attr_id and attr_value hold their last result after attr_valid falls, until the next pulse. attr_error does not change attr_value.
- Idle input cycles (char_valid low) freeze all state. Throughput is one character per cycle, with no backpressure.
- attr_valid and tag_done may assert together when the `>` terminates an unquoted value. attr_valid and attr_error never assert together.

## Structure
- Shared defines header holds:
  - `CHAR_BITES` and `ATTRIBUTE_VAL_BITES`.
  - Attribute id constants (ATTR_NONE..ATTR_SIZE).
  - FSM state encodings.
  - The character constants space, `=`, `"`, `>`.
- One sub-module, attr_name_match: combinational. Takes the name buffer and length and returns the 3-bit id.
- Digit conversion reuses the existing char_to_int converter. Classification (is_digit, is_letter) is local logic.

## Test plan
- `width="640" ` with char_valid high every cycle -> one attr_valid, id=1, value=640, the cycle after the closing quote.
- `height=2000>` -> attr_valid with id=2 and value=1023 (saturated), and tag_done in the same cycle.
- `size="1x" x=5 ` -> attr_error when `x` is consumed, then the parser resyncs: attr_valid with id=3 and value=5.
- `colour="12" y="7"` with char_valid toggling every other cycle -> colour produces no pulse; one attr_valid with id=4 and value=7.
- `width="12` then reset asserted mid-value -> all outputs 0 at once. After release, `x=3 ` yields id=3, value=3.
- `hidden title="a>b" x=1` -> tag_done at the `>` inside the quotes. tag_active dropped at the same time -> no attr_valid for the rest.
